// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the load/store unit.
// Optional stall performance counters are enabled with `define ARB_PERF_CNT_EN.
module mem_port_arbiter #(
    parameter int unsigned ADDR_WIDTH   = 32,
    parameter int unsigned WORD_WIDTH   = 32,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    input  logic                    if_flush,
    output logic                    if_rvalid,
    output logic [WORD_WIDTH-1:0]   if_rdata,
    output logic                    if_stall,
    input  logic                    dm_req,
    input  logic                    dm_we,
    input  logic [ADDR_WIDTH-1:0]   dm_addr,
    input  logic [WORD_WIDTH-1:0]   dm_wdata,
    input  logic [WORD_WIDTH/8-1:0] dm_be,
    output logic                    dm_done,
    output logic [WORD_WIDTH-1:0]   dm_rdata,
    output logic                    dm_stall,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [WORD_WIDTH-1:0]   mem_wdata,
    output logic [WORD_WIDTH/8-1:0] mem_be,
    input  logic                    mem_ack,
    input  logic [WORD_WIDTH-1:0]   mem_rdata,
    output logic [31:0]             perf_if_stall_cnt,
    output logic [31:0]             perf_dm_stall_cnt
);

    typedef enum logic [1:0] {IDLE, IF_XFER, DM_XFER} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state, state_next;
    logic [3:0] starve_cnt;
    logic       kill;
    logic       grant_if, grant_dm;

    assign if_stall = if_req & ~if_rvalid;
    assign dm_stall = dm_req & ~dm_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        grant_if   = 1'b0;
        grant_dm   = 1'b0;
        case (state)
            IDLE: begin
                // DM has priority unless a pending fetch has waited out LIMIT grants
                if (dm_req && !(if_req && starve_cnt >= LIMIT)) begin
                    grant_dm   = 1'b1;
                    state_next = DM_XFER;
                end else if (if_req) begin
                    grant_if   = 1'b1;
                    state_next = IF_XFER;
                end
            end
            IF_XFER, DM_XFER: if (mem_ack) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
        end else if (grant_dm) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_be    <= dm_be;
        end else if (grant_if) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_be    <= '1;
        end else if (state != IDLE && mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_rvalid <= 1'b0;
            if_rdata  <= '0;
            dm_done   <= 1'b0;
            dm_rdata  <= '0;
        end else begin
            if_rvalid <= 1'b0;
            dm_done   <= 1'b0;
            // a flush arriving in the ack cycle itself must also drop the data
            if (state == IF_XFER && mem_ack && !(kill || if_flush)) begin
                if_rvalid <= 1'b1;
                if_rdata  <= mem_rdata;
            end
            if (state == DM_XFER && mem_ack) begin
                dm_done <= 1'b1;
                if (!mem_we) dm_rdata <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kill <= 1'b0;
        end else if (state == IDLE) begin
            kill <= grant_if & if_flush;
        end else if (state == IF_XFER) begin
            kill <= mem_ack ? 1'b0 : (kill | if_flush);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (grant_dm && if_req) begin
            if (starve_cnt != 4'hF) starve_cnt <= starve_cnt + 4'd1;
        end else if (grant_if || (state == IDLE && !if_req)) begin
            starve_cnt <= '0;
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_if_stall_cnt <= '0;
            perf_dm_stall_cnt <= '0;
        end else begin
            if (if_stall) perf_if_stall_cnt <= perf_if_stall_cnt + 32'd1;
            if (dm_stall) perf_dm_stall_cnt <= perf_dm_stall_cnt + 32'd1;
        end
    end
`else
    assign perf_if_stall_cnt = '0;
    assign perf_dm_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: expected read data is queued when a request is
// driven and popped when if_rvalid/dm_done fires; a behavioural memory answers mem_req.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0, if_flush = 1'b0, if_rvalid, if_stall;
    logic [31:0] if_addr = '0, if_rdata;
    logic        dm_req = 1'b0, dm_we = 1'b0, dm_done, dm_stall;
    logic [31:0] dm_addr = '0, dm_wdata = '0, dm_rdata;
    logic [3:0]  dm_be = '0, mem_be;
    logic        mem_req, mem_we;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic [31:0] perf_if_stall_cnt, perf_dm_stall_cnt;

    int errors = 0;
    int checks = 0;
    int ack_delay = 0;
    int wait_cnt = 0;

    logic [31:0] mem_arr [logic [31:0]];
    logic [31:0] exp_if_q [$];
    logic [31:0] exp_dm_q [$];

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_WIDTH(32),
        .WORD_WIDTH(32),
        .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_done(dm_done), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .perf_if_stall_cnt(perf_if_stall_cnt), .perf_dm_stall_cnt(perf_dm_stall_cnt)
    );

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_arr.exists(a)) return mem_arr[a];
        return ~a;
    endfunction

    // Memory answers after ack_delay cycles of mem_req; the ack lasts one cycle.
    always @(negedge clk) begin
        if (mem_req && !mem_ack && wait_cnt == ack_delay) begin
            logic [31:0] w;
            mem_ack   = 1'b1;
            mem_rdata = mem_read(mem_addr);
            if (mem_we) begin
                w = mem_read(mem_addr);
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                mem_arr[mem_addr] = w;
            end
        end else begin
            mem_ack = 1'b0;
            if (mem_req) wait_cnt = wait_cnt + 1;
            else         wait_cnt = 0;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        if_req = 1'b1;
        #1;
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_be !== 4'h0) begin errors++; $display("FAIL reset_mem_bus: got addr %h wdata %h be %h want 0", mem_addr, mem_wdata, mem_be); end
        checks++; if (if_rvalid !== 1'b0 || dm_done !== 1'b0) begin errors++; $display("FAIL reset_pulses: got rvalid %b done %b want 0", if_rvalid, dm_done); end
        checks++; if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got if %h dm %h want 0", if_rdata, dm_rdata); end
        checks++; if (if_stall !== 1'b1 || dm_stall !== 1'b0) begin errors++; $display("FAIL reset_stalls: got if %b dm %b want 1 0", if_stall, dm_stall); end
        checks++; if (perf_if_stall_cnt !== 32'h0 || perf_dm_stall_cnt !== 32'h0) begin errors++; $display("FAIL reset_perf: got %0d %0d want 0 0", perf_if_stall_cnt, perf_dm_stall_cnt); end
        if_req = 1'b0;
        rst = 1'b1;
        step();
        checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL idle_mem_req: got %b want 0", mem_req); end
    endtask

    task automatic test_if_fetch();
        int  stall_cycles = 0;
        bit  seen = 1'b0;
        bit  bus_checked = 1'b0;
        mem_arr[32'h10] = 32'h0050_0093;
        ack_delay = 0;
        if_addr = 32'h10;
        if_req = 1'b1;
        exp_if_q.push_back(32'h0050_0093);
        #1;
        for (int n = 0; n < 20 && !seen; n++) begin
            if (if_rvalid) begin
                seen = 1'b1;
                checks++; if (exp_if_q.size() == 0 || if_rdata !== exp_if_q[0]) begin errors++; $display("FAIL fetch_rdata: got %h want 00500093", if_rdata); end
                if (exp_if_q.size() != 0) void'(exp_if_q.pop_front());
                if_req = 1'b0;
            end else begin
                if (if_stall) stall_cycles++;
                if (mem_req && !bus_checked) begin
                    bus_checked = 1'b1;
                    checks++; if (mem_addr !== 32'h10 || mem_we !== 1'b0) begin errors++; $display("FAIL fetch_bus: got addr %h we %b want 00000010 0", mem_addr, mem_we); end
                end
                step();
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL fetch_timeout: got no if_rvalid want pulse"); end
        checks++; if (stall_cycles != 2) begin errors++; $display("FAIL fetch_stall_cycles: got %0d want 2", stall_cycles); end
        step();
        checks++; if (if_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_single_pulse: got %b want 0", if_rvalid); end
`ifdef ARB_PERF_CNT_EN
        checks++; if (perf_if_stall_cnt !== 32'd2 || perf_dm_stall_cnt !== 32'd0) begin errors++; $display("FAIL perf_counts: got %0d %0d want 2 0", perf_if_stall_cnt, perf_dm_stall_cnt); end
`else
        checks++; if (perf_if_stall_cnt !== 32'd0 || perf_dm_stall_cnt !== 32'd0) begin errors++; $display("FAIL perf_disabled: got %0d %0d want 0 0", perf_if_stall_cnt, perf_dm_stall_cnt); end
`endif
    endtask

    task automatic test_dm_priority();
        bit seen = 1'b0;
        mem_arr[32'h20] = 32'h1111_1111;
        ack_delay = 0;
        if_addr = 32'h20; if_req = 1'b1;
        dm_addr = 32'h100; dm_we = 1'b1; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'hF; dm_req = 1'b1;
        exp_if_q.push_back(32'h1111_1111);
        exp_dm_q.push_back(32'h0);
        #1;
        for (int n = 0; n < 10 && !mem_req; n++) step();
        checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100) begin errors++; $display("FAIL dm_wins: got req %b we %b addr %h want 1 1 00000100", mem_req, mem_we, mem_addr); end
        checks++; if (mem_wdata !== 32'hDEAD_BEEF || mem_be !== 4'hF) begin errors++; $display("FAIL dm_store_bus: got wdata %h be %h want deadbeef f", mem_wdata, mem_be); end
        for (int n = 0; n < 10 && !seen; n++) begin
            step();
            if (dm_done) begin
                seen = 1'b1;
                checks++; if (exp_dm_q.size() == 0 || dm_rdata !== exp_dm_q[0]) begin errors++; $display("FAIL store_rdata_hold: got %h want 00000000", dm_rdata); end
                if (exp_dm_q.size() != 0) void'(exp_dm_q.pop_front());
                checks++; if (dm_stall !== 1'b0 || if_rvalid !== 1'b0) begin errors++; $display("FAIL store_done_cycle: got dm_stall %b if_rvalid %b want 0 0", dm_stall, if_rvalid); end
                dm_req = 1'b0; dm_we = 1'b0;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL store_timeout: got no dm_done want pulse"); end
        checks++; if (mem_read(32'h100) !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_written: got %h want deadbeef", mem_read(32'h100)); end
        step();
        checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h20) begin errors++; $display("FAIL if_after_bubble: got req %b addr %h want 1 00000020", mem_req, mem_addr); end
        seen = 1'b0;
        for (int n = 0; n < 10 && !seen; n++) begin
            step();
            if (if_rvalid) begin
                seen = 1'b1;
                checks++; if (exp_if_q.size() == 0 || if_rdata !== exp_if_q[0]) begin errors++; $display("FAIL second_fetch_rdata: got %h want 11111111", if_rdata); end
                if (exp_if_q.size() != 0) void'(exp_if_q.pop_front());
                if_req = 1'b0;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL second_fetch_timeout: got no if_rvalid want pulse"); end
        step();
    endtask

    task automatic test_starvation();
        logic [31:0] grants [$];
        int dm_n = 0;
        int if_n = 0;
        bit prev = 1'b0;
        ack_delay = 0;
        if_addr = 32'h200; if_req = 1'b1;
        dm_addr = 32'h300; dm_we = 1'b0; dm_be = 4'hF; dm_req = 1'b1;
        exp_if_q.push_back(mem_read(32'h200));
        exp_dm_q.push_back(mem_read(32'h300));
        for (int n = 0; n < 100 && if_n < 2; n++) begin
            step();
            if (mem_req && !prev) grants.push_back(mem_addr);
            prev = mem_req;
            if (dm_done) begin
                checks++; if (exp_dm_q.size() == 0 || dm_rdata !== exp_dm_q[0]) begin errors++; $display("FAIL starve_load_%0d: got %h want %h", dm_n, dm_rdata, mem_read(dm_addr)); end
                if (exp_dm_q.size() != 0) void'(exp_dm_q.pop_front());
                dm_n++;
                if (dm_n == 8) dm_req = 1'b0;
                else begin
                    dm_addr = dm_addr + 32'd4;
                    exp_dm_q.push_back(mem_read(dm_addr));
                end
            end
            if (if_rvalid) begin
                checks++; if (exp_if_q.size() == 0 || if_rdata !== exp_if_q[0]) begin errors++; $display("FAIL starve_fetch_%0d: got %h want %h", if_n, if_rdata, mem_read(if_addr)); end
                if (exp_if_q.size() != 0) void'(exp_if_q.pop_front());
                if_n++;
                if (if_n == 1) begin
                    if_addr = 32'h204;
                    exp_if_q.push_back(mem_read(32'h204));
                end else begin
                    if_req = 1'b0;
                end
            end
        end
        checks++; if (grants.size() != 10) begin errors++; $display("FAIL starve_grant_count: got %0d want 10", grants.size()); end
        for (int i = 0; i < grants.size() && i < 10; i++) begin
            checks++;
            if ((grants[i] < 32'h300) != (i == 4 || i == 9)) begin
                errors++; $display("FAIL starve_order_%0d: got addr %h want %s grant", i, grants[i], (i == 4 || i == 9) ? "IF" : "DM");
            end
        end
        step();
    endtask

    task automatic test_flush();
        bit seen = 1'b0;
        int n_grants = 0;
        bit prev;
        mem_arr[32'h40] = 32'h0BAD_F00D;
        mem_arr[32'h80] = 32'hCAFE_F00D;
        ack_delay = 3;
        if_addr = 32'h40; if_req = 1'b1;
        #1;
        for (int n = 0; n < 10 && !mem_req; n++) step();
        n_grants = mem_req ? 1 : 0;
        prev = mem_req;
        if_flush = 1'b1;
        if_addr = 32'h80;
        exp_if_q.push_back(32'hCAFE_F00D);
        step();
        if_flush = 1'b0;
        for (int n = 0; n < 30 && !seen; n++) begin
            step();
            if (mem_req && !prev) n_grants++;
            prev = mem_req;
            if (if_rvalid) begin
                seen = 1'b1;
                checks++; if (exp_if_q.size() == 0 || if_rdata !== exp_if_q[0]) begin errors++; $display("FAIL flush_rdata: got %h want cafef00d", if_rdata); end
                if (exp_if_q.size() != 0) void'(exp_if_q.pop_front());
                checks++; if (n_grants != 2) begin errors++; $display("FAIL flush_refetch_grants: got %0d want 2", n_grants); end
                if_req = 1'b0;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL flush_timeout: got no if_rvalid want pulse"); end
        step();

        // flush coinciding with the grant cycle
        seen = 1'b0;
        mem_arr[32'h50] = 32'h1234_5678;
        ack_delay = 0;
        if_addr = 32'h44; if_req = 1'b1; if_flush = 1'b1;
        step();
        if_flush = 1'b0;
        if_addr = 32'h50;
        exp_if_q.push_back(32'h1234_5678);
        for (int n = 0; n < 20 && !seen; n++) begin
            step();
            if (if_rvalid) begin
                seen = 1'b1;
                checks++; if (exp_if_q.size() == 0 || if_rdata !== exp_if_q[0]) begin errors++; $display("FAIL grant_flush_rdata: got %h want 12345678", if_rdata); end
                if (exp_if_q.size() != 0) void'(exp_if_q.pop_front());
                if_req = 1'b0;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL grant_flush_timeout: got no if_rvalid want pulse"); end
        step();
    endtask

    task automatic test_async_reset();
        bit seen = 1'b0;
        ack_delay = 1000;
        dm_addr = 32'h100; dm_we = 1'b0; dm_be = 4'hF; dm_req = 1'b1;
        #1;
        for (int n = 0; n < 10 && !mem_req; n++) step();
        step();
        checks++; if (mem_req !== 1'b1 || dm_stall !== 1'b1) begin errors++; $display("FAIL withheld_xfer: got req %b stall %b want 1 1", mem_req, dm_stall); end
        rst = 1'b0;
        #1;
        checks++; if (mem_req !== 1'b0 || dm_done !== 1'b0) begin errors++; $display("FAIL async_reset_abort: got req %b done %b want 0 0", mem_req, dm_done); end
        checks++; if (perf_dm_stall_cnt !== 32'h0) begin errors++; $display("FAIL async_reset_perf: got %0d want 0", perf_dm_stall_cnt); end
        dm_req = 1'b0;
        step();
        ack_delay = 0;
        rst = 1'b1;
        step();
        dm_req = 1'b1;
        exp_dm_q.push_back(32'hDEAD_BEEF);
        for (int n = 0; n < 10 && !seen; n++) begin
            step();
            if (dm_done) begin
                seen = 1'b1;
                checks++; if (exp_dm_q.size() == 0 || dm_rdata !== exp_dm_q[0]) begin errors++; $display("FAIL post_reset_load: got %h want deadbeef", dm_rdata); end
                if (exp_dm_q.size() != 0) void'(exp_dm_q.pop_front());
                dm_req = 1'b0;
            end
        end
        checks++; if (!seen) begin errors++; $display("FAIL post_reset_timeout: got no dm_done want pulse"); end
        step();
        checks++; if (exp_if_q.size() != 0 || exp_dm_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: got %0d %0d left want 0 0", exp_if_q.size(), exp_dm_q.size()); end
    endtask

    initial begin
        test_reset();
        test_if_fetch();
        test_dm_priority();
        test_starvation();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
